// File: rtl/potential_decay_array_pkg.sv
// Shared neuron definitions: sweep FSM encoding and FP32 field layout used by
// the potential array and any neuron model that manipulates FP32 exponents.
package potential_decay_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_MSB  = 22;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX  = 8'hFF;
  localparam logic [FP_EXP_W-1:0] FP_EXP_ZERO = 8'h00;

  // Zero carrying the sign of the input; used wherever a value is flushed.
  function automatic logic [FP_W-1:0] fp_signed_zero(input logic [FP_W-1:0] value);
    fp_signed_zero = {value[FP_SIGN_BIT], {(FP_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/potential_decay_array_fp_exp_shift.sv
// Multiplies an FP32 value by 2**-rate by lowering its exponent; results that
// would become denormal are flushed to a signed zero, Inf/NaN pass untouched.
module fp_exp_shift
  import potential_decay_array_pkg::*;
#(
  parameter int RATE_W = 3
) (
  input  logic [FP_W-1:0]   value_in,
  input  logic [RATE_W-1:0] rate,
  output logic [FP_W-1:0]   value_out
);

  logic [FP_EXP_W-1:0] exp_in;
  logic [FP_EXP_W:0]   rate_ext;
  logic [FP_EXP_W-1:0] exp_out;

  assign exp_in   = value_in[FP_EXP_MSB:FP_EXP_LSB];
  assign rate_ext = (FP_EXP_W+1)'(rate);
  assign exp_out  = exp_in - rate_ext[FP_EXP_W-1:0];

  always_comb begin
    value_out = value_in;
    if (exp_in == FP_EXP_MAX) begin
      value_out = value_in;
    end else if (exp_in == FP_EXP_ZERO) begin
      value_out = fp_signed_zero(value_in);
    end else if (rate == '0) begin
      value_out = value_in;
    end else if ({1'b0, exp_in} <= rate_ext) begin
      value_out = fp_signed_zero(value_in);
    end else begin
      value_out = {value_in[FP_SIGN_BIT], exp_out, value_in[FP_MAN_MSB:0]};
    end
  end

endmodule

// File: rtl/potential_decay_array.sv
// Register array of FP32 neuron potentials with per-slot decay rate; a clear
// strobe streams every slot out decayed and writes the decayed value back.
module potential_decay_array
  import potential_decay_array_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int RATE_W      = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_init,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FP_W-1:0]   wr_potential,
  input  logic [RATE_W-1:0] wr_rate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [FP_W-1:0]   out_potential,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   NUM_LIMIT = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_NEURONS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                overrun_q, overrun_d;

  logic [FP_W-1:0]     slot_potential [NUM_NEURONS];
  logic [RATE_W-1:0]   slot_rate      [NUM_NEURONS];

  logic                addr_in_range;
  logic                wr_fire;
  logic                out_fire;
  logic [FP_W-1:0]     sel_potential;
  logic [RATE_W-1:0]   sel_rate;
  logic [FP_W-1:0]     decayed;

  assign addr_in_range = ({1'b0, wr_addr} < NUM_LIMIT);
  assign wr_fire       = wr_valid && wr_ready && addr_in_range;
  assign out_fire      = out_valid && out_ready;
  assign sel_potential = slot_potential[idx_q];
  assign sel_rate      = slot_rate[idx_q];

  fp_exp_shift #(
    .RATE_W(RATE_W)
  ) u_decay (
    .value_in (sel_potential),
    .rate     (sel_rate),
    .value_out(decayed)
  );

  // Writes only land in IDLE and writeback only in SWEEP, so the two never collide.
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
    logic [FP_W-1:0]   potential_q, potential_d;
    logic [RATE_W-1:0] rate_q, rate_d;

    always_comb begin
      potential_d = potential_q;
      rate_d      = rate_q;
      if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
        potential_d = wr_potential;
        if (wr_init) begin
          rate_d = wr_rate;
        end
      end else if (out_fire && (idx_q == ADDR_W'(gi))) begin
        potential_d = decayed;
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        potential_q <= '0;
        rate_q      <= '0;
      end else begin
        potential_q <= potential_d;
        rate_q      <= rate_d;
      end
    end

    assign slot_potential[gi] = potential_q;
    assign slot_rate[gi]      = rate_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    // A clear arriving while a sweep is still in flight is a lost timestep.
    overrun_d = overrun_q || (clear && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ready      = (state_q == ST_IDLE);
    out_valid     = (state_q == ST_SWEEP);
    busy          = (state_q == ST_SWEEP);
    done          = (state_q == ST_DONE);
    out_addr      = idx_q;
    out_potential = (state_q == ST_SWEEP) ? decayed : '0;
    overrun       = overrun_q;
  end

endmodule

// File: tb/tb_potential_decay_array.sv
// Directed bench for potential_decay_array: table of slot writes with
// hand-computed decays over two sweeps, plus stall, overrun and reset cases.
module tb_potential_decay_array;

  logic        CLK;
  logic        RESET_N;
  logic        clear;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_init;
  logic [3:0]  wr_addr;
  logic [31:0] wr_potential;
  logic [2:0]  wr_rate;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_potential;
  logic        busy;
  logic        done;
  logic        overrun;

  potential_decay_array #(
    .NUM_NEURONS(16),
    .ADDR_W     (4),
    .RATE_W     (3)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .clear        (clear),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_init      (wr_init),
    .wr_addr      (wr_addr),
    .wr_potential (wr_potential),
    .wr_rate      (wr_rate),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_potential(out_potential),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] pot;
    logic [2:0]  rate;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] exp_mem [16];
  int          tests_run;
  int          tests_failed;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic write_slot(input logic [3:0] addr, input logic [31:0] pot,
                            input logic [2:0] rate, input logic init);
    wr_valid     = 1'b1;
    wr_addr      = addr;
    wr_potential = pot;
    wr_rate      = rate;
    wr_init      = init;
    chk("wr_ready_idle", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    $display("[TB] write slot %0d = %h rate %0d init %0d", addr, pot, rate, init);
  endtask

  task automatic run_sweep(input int stall_idx, input int clear_idx, input int wr_idx,
                           input int stop_idx, input bit check_pot);
    logic [31:0] held;
    for (int i = 0; i < 16; i++) begin
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("out_addr", {28'b0, out_addr}, i);
      if (check_pot) chk("out_potential", out_potential, exp_mem[i]);
      chk("busy", {31'b0, busy}, 32'd1);
      chk("wr_ready_sweep", {31'b0, wr_ready}, 32'd0);
      chk("done_mid_sweep", {31'b0, done}, 32'd0);
      $display("[TB] sweep idx %0d out %h", out_addr, out_potential);
      if (i == stop_idx) return;
      if (i == stall_idx) begin
        held      = out_potential;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_addr", {28'b0, out_addr}, i);
          chk("stall_potential", out_potential, held);
        end
        out_ready = 1'b1;
      end
      if (i == clear_idx) clear = 1'b1;
      if (i == wr_idx) begin
        wr_valid     = 1'b1;
        wr_addr      = 4'd13;
        wr_potential = 32'h12345678;
        wr_rate      = 3'd0;
        wr_init      = 1'b1;
      end
      tick();
      clear    = 1'b0;
      wr_valid = 1'b0;
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("out_valid_done", {31'b0, out_valid}, 32'd0);
    chk("busy_done", {31'b0, busy}, 32'd0);
    tick();
    chk("done_after", {31'b0, done}, 32'd0);
    chk("wr_ready_after", {31'b0, wr_ready}, 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vecs[0]  = '{4'd0,  32'h40000000, 3'd1, 32'h3F800000, 32'h3F000000};
    vecs[1]  = '{4'd1,  32'h41200000, 3'd0, 32'h41200000, 32'h41200000};
    vecs[2]  = '{4'd2,  32'h42000000, 3'd4, 32'h40000000, 32'h3E000000};
    vecs[3]  = '{4'd3,  32'hC1000000, 3'd3, 32'hBF800000, 32'hBE000000};
    vecs[4]  = '{4'd4,  32'h7F800000, 3'd2, 32'h7F800000, 32'h7F800000};
    vecs[5]  = '{4'd5,  32'h00800000, 3'd1, 32'h00000000, 32'h00000000};
    vecs[6]  = '{4'd6,  32'h81000000, 3'd3, 32'h80000000, 32'h80000000};
    vecs[7]  = '{4'd7,  32'h7FC00000, 3'd5, 32'h7FC00000, 32'h7FC00000};
    vecs[8]  = '{4'd8,  32'h3F800000, 3'd7, 32'h3C000000, 32'h38800000};
    vecs[9]  = '{4'd9,  32'h00000001, 3'd2, 32'h00000000, 32'h00000000};
    vecs[10] = '{4'd10, 32'h80000000, 3'd0, 32'h80000000, 32'h80000000};
    vecs[11] = '{4'd11, 32'h83800000, 3'd7, 32'h80000000, 32'h80000000};
    vecs[12] = '{4'd12, 32'h04000000, 3'd7, 32'h00800000, 32'h00000000};
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

    RESET_N      = 1'b0;
    clear        = 1'b0;
    wr_valid     = 1'b0;
    wr_init      = 1'b0;
    wr_addr      = '0;
    wr_potential = '0;
    wr_rate      = '0;
    out_ready    = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_out_addr", {28'b0, out_addr}, 32'd0);
    chk("rst_out_potential", out_potential, 32'd0);
    RESET_N = 1'b1;
    tick();
    chk("wr_ready_after_rst", {31'b0, wr_ready}, 32'd1);

    // Sweep 1: table values, stall at 2, lost clear at 7, blocked write at 12.
    foreach (vecs[k]) begin
      write_slot(vecs[k].addr, vecs[k].pot, vecs[k].rate, 1'b1);
      exp_mem[vecs[k].addr] = vecs[k].exp1;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("overrun_before", {31'b0, overrun}, 32'd0);
    run_sweep(2, 7, 12, -1, 1'b1);
    chk("overrun_set", {31'b0, overrun}, 32'd1);

    // Sweep 2: decay of writeback, potential-only write, write coinciding with clear.
    foreach (vecs[k]) exp_mem[vecs[k].addr] = vecs[k].exp2;
    write_slot(4'd1, 32'h40400000, 3'd7, 1'b0);
    exp_mem[1] = 32'h40400000;
    clear = 1'b1;
    write_slot(4'd2, 32'h40800000, 3'd2, 1'b1);
    clear = 1'b0;
    exp_mem[2] = 32'h3F800000;
    run_sweep(-1, -1, -1, -1, 1'b1);
    chk("overrun_sticky", {31'b0, overrun}, 32'd1);

    // Sweep 3: abandoned by reset at index 9, then a sweep of all zeros.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run_sweep(-1, -1, -1, 9, 1'b0);
    RESET_N = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_overrun", {31'b0, overrun}, 32'd0);
    chk("abort_out_addr", {28'b0, out_addr}, 32'd0);
    chk("abort_out_potential", out_potential, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("wr_ready_after_abort", {31'b0, wr_ready}, 32'd1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run_sweep(-1, -1, -1, -1, 1'b1);
    chk("overrun_clean", {31'b0, overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/potential_decay_array.md
POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 16, the number of neuron potential slots held.
REQ-002 The block SHALL have parameter ADDR_W, default 4, the neuron address width, with 2**ADDR_W >= NUM_NEURONS.
REQ-003 The block SHALL have parameter RATE_W, default 3, the decay-shift field width; shift = 2**-rate.
REQ-004 Ports, as name  direction  width  meaning:
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  timestep strobe; starts one decay sweep.
REQ-008 wr_valid / wr_ready  in / out  1 / 1  write handshake.
REQ-009 wr_init  in  1  1 = write potential and rate; 0 = write potential only (adder result).
REQ-010 wr_addr / wr_potential / wr_rate  in  ADDR_W / 32 / RATE_W  write target, FP32 value, decay shift.
REQ-011 out_valid / out_ready  out / in  1 / 1  decayed-potential stream handshake.
REQ-012 out_addr / out_potential  out  ADDR_W / 32  neuron index and decayed FP32 value.
REQ-013 busy / done / overrun  out  1 / 1 / 1  sweep active; one-cycle sweep-end pulse; sticky lost-clear flag.

Function
REQ-014 The block SHALL hold NUM_NEURONS FP32 potentials and RATE_W-bit rates in internal registers.
REQ-015 The FSM SHALL have states IDLE, SWEEP and DONE.
REQ-016 In IDLE, wr_ready SHALL be 1 and a wr_valid&wr_ready edge SHALL write the slot at the next edge; wr_addr >= NUM_NEURONS SHALL be dropped.
REQ-017 clear sampled high in IDLE SHALL move to SWEEP with index 0; when wr_valid and clear coincide, the write SHALL complete first.
REQ-018 In SWEEP, wr_ready SHALL be 0, busy SHALL be 1, and out_valid SHALL be 1 with out_addr = index and out_potential = decay(slot[index]).
REQ-019 out_valid SHALL assert the cycle after clear is sampled (latency 1).
REQ-020 While out_ready is 0, out_addr and out_potential SHALL hold stable.
REQ-021 On out_valid&out_ready, the slot SHALL be overwritten with the decayed value and the index SHALL increment.
REQ-022 A handshake at index NUM_NEURONS-1 SHALL move to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and out_valid=0, then return to IDLE.
REQ-024 Decay SHALL follow these rules:
- sign and mantissa unchanged; exponent E reduced by rate;
- E==255 (Inf/NaN) passes unchanged;
- E==0 (zero/denormal) gives a signed zero;
- 0 < E <= rate gives a signed zero (flush, no denormals);
- rate==0 passes unchanged.
REQ-025 clear sampled high in SWEEP or DONE SHALL be ignored for sweeping and SHALL set overrun to 1 until reset.

Reset
REQ-026 RESET_N low SHALL immediately clear all slots and rates to 0.
REQ-027 RESET_N low SHALL set state IDLE, index 0, out_valid=0, out_addr=0, out_potential=0, busy=0, done=0 and overrun=0, with wr_ready=1 after release.
REQ-028 Reset mid-sweep SHALL abandon the sweep with no further writeback.

Structure
REQ-029 FSM state encodings and FP32 field constants (exponent 255, bit positions) SHALL reside in the shared neuron package/header.
REQ-030 The per-value decay function SHALL be a combinational sub-module fp_exp_shift (32-bit in, RATE_W rate in, 32-bit out), reusable by other neuron models.

Verification
REQ-031 Slot 0 written 0x40000000 with rate 1, clear, out_ready=1 -> out_valid next cycle, out_addr 0, out_potential 0x3F800000; re-read after the sweep shows 0x3F800000 stored.
REQ-032 Slot 3 written 0xC1000000 with rate 3 -> 0xBF800000; slot 4 written 0x7F800000 with rate 2 -> 0x7F800000; rate 0 on 0x41200000 -> 0x41200000.
REQ-033 Slot 5 written 0x00800000 with rate 1 -> 0x00000000; slot 6 written 0x81000000 with rate 3 -> 0x80000000.
REQ-034 out_ready held 0 for 5 cycles at index 2 -> out_addr 2 and value stable, no index advance; sweep finishes with done pulsing exactly once after the handshake at index 15.
REQ-035 clear pulsed at index 7 -> overrun=1 and the sweep continues unaffected; wr_valid during SWEEP -> wr_ready=0 and the slot is unchanged.
REQ-036 RESET_N low at index 9 -> out_valid=0, busy=0, all slots 0; a subsequent clear sweeps zeros, with out_potential 0x00000000 for all 16 slots.
